sram_march_bist: RTL and testbench

//  Initiator-side March C- self-test engine for one 1RW+1R 32x512 OpenRAM macro, operating the

---
 rtl/sram_march_bist.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
// March C- self-test engine for a 1RW+1R OpenRAM macro.
// One SRAM command per cycle is driven straight from flops. The expected read value,
// address and element ride a two-stage pipeline that matches the macro's read latency,
// so each read is checked one edge after the macro captures it. The first miscompare is
// latched, and every miscompare bumps a saturating counter.
module sram_march_bist #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 9,
   parameter logic [DATA_WIDTH-1:0] BG         = 32'h5555_5555,
   parameter int                    READ_PORT  = 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [15:0]           err_count,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [3:0]            sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [2:0]            ELEM_LAST = 3'd5;

   // Elements 3 and 4 walk the address space downwards.
   function automatic logic f_down(input logic [2:0] elem);
      return (elem == 3'd3) || (elem == 3'd4);
   endfunction

   // Elements 1..4 are read-then-write pairs; elements 0 and 5 are single ops.
   function automatic logic f_pair(input logic [2:0] elem);
      return (elem != 3'd0) && (elem != ELEM_LAST);
   endfunction

   // Op 0 of every element except the initial fill is a read.
   function automatic logic f_is_read(input logic [2:0] elem, input logic op);
      return (elem != 3'd0) && (op == 1'b0);
   endfunction

   // Data of an op: reads in E2/E4 and writes in E1/E3 use the inverted background.
   function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [2:0] elem, input logic op);
      logic inv;
      if (f_is_read(elem, op)) begin
         inv = (elem == 3'd2) || (elem == 3'd4);
      end else begin
         inv = (elem == 3'd1) || (elem == 3'd3);
      end
      return inv ? ~BG : BG;
   endfunction

   logic [1:0]            r_state;
   logic [2:0]            r_elem;
   logic                  r_op;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_arm;
   logic                  r_cmd_rd;
   logic [DATA_WIDTH-1:0] r_cmd_exp;
   logic [2:0]            r_cmd_elem;
   logic [ADDR_WIDTH-1:0] r_cmd_addr;
   logic                  r_chk_v;
   logic [DATA_WIDTH-1:0] r_chk_exp;
   logic [2:0]            r_chk_elem;
   logic [ADDR_WIDTH-1:0] r_chk_addr;

   logic                  w_op_last;
   logic                  w_addr_end;
   logic                  w_last_cmd;
   logic [2:0]            w_nxt_elem;
   logic                  w_nxt_op;
   logic [ADDR_WIDTH-1:0] w_nxt_addr;
   logic                  w_start_ok;
   logic                  w_issue;
   logic [2:0]            w_cmd_elem;
   logic                  w_cmd_op;
   logic [ADDR_WIDTH-1:0] w_cmd_addr;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [DATA_WIDTH-1:0] w_diff;
   logic                  w_miss;

   // start is only honoured when idle/done and not on the first edge after reset release
   assign w_start_ok = start & r_arm & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_rd_data  = (READ_PORT != 0) ? sram_dout1 : sram_dout0;
   assign w_diff     = w_rd_data ^ r_chk_exp;
   assign w_miss     = |w_diff;

   // Successor of the command currently driven: next op, next address, or next element
   always_comb begin
      w_op_last  = f_pair(r_elem) ? r_op : 1'b1;
      w_addr_end = f_down(r_elem) ? (r_addr == ADDR_ZERO) : (r_addr == ADDR_MAX);
      w_nxt_elem = r_elem;
      w_nxt_op   = 1'b0;
      w_nxt_addr = r_addr;
      w_last_cmd = 1'b0;
      if (!w_op_last) begin
         w_nxt_op = 1'b1;
      end else if (!w_addr_end) begin
         w_nxt_addr = f_down(r_elem) ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
      end else if (r_elem == ELEM_LAST) begin
         w_last_cmd = 1'b1;
      end else begin
         w_nxt_elem = r_elem + 3'd1;
         w_nxt_addr = f_down(r_elem + 3'd1) ? ADDR_MAX : ADDR_ZERO;
      end
   end

   // Pick the command to load this cycle: the first E0 write on start, else the successor
   always_comb begin
      w_issue    = 1'b0;
      w_cmd_elem = w_nxt_elem;
      w_cmd_op   = w_nxt_op;
      w_cmd_addr = w_nxt_addr;
      if (w_start_ok) begin
         w_issue    = 1'b1;
         w_cmd_elem = 3'd0;
         w_cmd_op   = 1'b0;
         w_cmd_addr = ADDR_ZERO;
      end else if ((r_state == S_RUN) && !w_last_cmd) begin
         w_issue = 1'b1;
      end else begin
         w_issue = 1'b0;
      end
   end

   // Sequencer: run state, command counters and busy/done flags
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= S_IDLE;
         r_elem  <= 3'd0;
         r_op    <= 1'b0;
         r_addr  <= ADDR_ZERO;
         r_arm   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_arm <= 1'b1;
         if (w_issue) begin
            r_elem <= w_cmd_elem;
            r_op   <= w_cmd_op;
            r_addr <= w_cmd_addr;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  r_state <= S_RUN;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_last_cmd) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               r_state <= S_DONE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // Drive the macro pins from flops and tag each read with its expected data
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= 4'h0;
         sram_addr0  <= ADDR_ZERO;
         sram_din0   <= DATA_ZERO;
         sram_csb1   <= 1'b1;
         sram_addr1  <= ADDR_ZERO;
         r_cmd_rd    <= 1'b0;
         r_cmd_exp   <= DATA_ZERO;
         r_cmd_elem  <= 3'd0;
         r_cmd_addr  <= ADDR_ZERO;
      end else if (w_issue) begin
         r_cmd_elem <= w_cmd_elem;
         r_cmd_addr <= w_cmd_addr;
         r_cmd_exp  <= f_pattern(w_cmd_elem, w_cmd_op);
         if (f_is_read(w_cmd_elem, w_cmd_op)) begin
            r_cmd_rd    <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= 4'h0;
            if (READ_PORT != 0) begin
               sram_csb0  <= 1'b1;
               sram_csb1  <= 1'b0;
               sram_addr1 <= w_cmd_addr;
            end else begin
               sram_csb0  <= 1'b0;
               sram_csb1  <= 1'b1;
               sram_addr0 <= w_cmd_addr;
            end
         end else begin
            r_cmd_rd    <= 1'b0;
            sram_csb0   <= 1'b0;
            sram_web0   <= 1'b0;
            sram_wmask0 <= 4'hF;
            sram_addr0  <= w_cmd_addr;
            sram_din0   <= f_pattern(w_cmd_elem, w_cmd_op);
            sram_csb1   <= 1'b1;
         end
      end else begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= 4'h0;
         sram_csb1   <= 1'b1;
         r_cmd_rd    <= 1'b0;
      end
   end

   // Second pipeline stage: the tag moves on as the macro captures the read
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_chk_v    <= 1'b0;
         r_chk_exp  <= DATA_ZERO;
         r_chk_elem <= 3'd0;
         r_chk_addr <= ADDR_ZERO;
      end else begin
         r_chk_v    <= r_cmd_rd;
         r_chk_exp  <= r_cmd_exp;
         r_chk_elem <= r_cmd_elem;
         r_chk_addr <= r_cmd_addr;
      end
   end

   // Record the first miscompare and count all of them; a new start clears the record
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         fail      <= 1'b0;
         fail_addr <= ADDR_ZERO;
         fail_elem <= 3'd0;
         fail_data <= DATA_ZERO;
         err_count <= 16'h0000;
      end else if (w_start_ok) begin
         fail      <= 1'b0;
         fail_addr <= ADDR_ZERO;
         fail_elem <= 3'd0;
         fail_data <= DATA_ZERO;
         err_count <= 16'h0000;
      end else if (r_chk_v && w_miss) begin
         if (!fail) begin
            fail_addr <= r_chk_addr;
            fail_elem <= r_chk_elem;
            fail_data <= w_diff;
         end
         fail <= 1'b1;
         if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'h0001;
         end
      end
   end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two instances (reads on port 1 and on port 0) each drive
// their own behavioural macro with an optional stuck-at bit. A March C- reference model
// predicts the command stream and the final result; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_sram_march_bist;
   localparam int          AW    = 9;
   localparam int          DW    = 32;
   localparam int          DEPTH = 512;
   localparam logic [31:0] BG    = 32'h5555_5555;
   // March C- as a table: ops per element, direction, op codes 0=w0 1=w1 2=r0 3=r1
   localparam int NOPS [6]    = '{1, 2, 2, 2, 2, 1};
   localparam int DOWN [6]    = '{0, 0, 0, 1, 1, 0};
   localparam int OPS  [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 2}};

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   typedef struct packed {
      logic          fail;
      logic [AW-1:0] addr;
      logic [2:0]    elem;
      logic [DW-1:0] data;
      logic [15:0]   err;
   } res_t;

   logic clk, rst, start;
   logic a_busy, a_done, a_fail, a_csb0, a_web0, a_csb1;
   logic [AW-1:0] a_faddr, a_addr0, a_addr1;
   logic [2:0] a_felem;
   logic [DW-1:0] a_fdata, a_din0, a_dout0, a_dout1;
   logic [15:0] a_err;
   logic [3:0] a_wmask0;
   logic b_busy, b_done, b_fail, b_csb0, b_web0, b_csb1;
   logic [AW-1:0] b_faddr, b_addr0, b_addr1;
   logic [2:0] b_felem;
   logic [DW-1:0] b_fdata, b_din0, b_dout0, b_dout1;
   logic [15:0] b_err;
   logic [3:0] b_wmask0;

   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, t0 = 0, cnt1 = 0, cnt0 = 0, dn1 = 0, dn0 = 0, exp_dn = 0;
   bit   prev1 = 1'b0, prev0 = 1'b0;
   bit   f_en = 1'b0, f_val = 1'b0;
   int   f_addr = 0, f_bit = 0;
   cmd_t q_cmd1[$], q_cmd0[$];
   res_t q_res1[$], q_res0[$];
   logic [31:0] mem1 [DEPTH];
   logic [31:0] mem0 [DEPTH];
   logic rp1 = 1'b0, rp0 = 1'b0;
   logic [AW-1:0] ra1 = '0, ra0 = '0;

   sram_march_bist #(.READ_PORT(1)) u_p1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .busy(a_busy), .done(a_done),
      .fail(a_fail), .fail_addr(a_faddr), .fail_elem(a_felem), .fail_data(a_fdata),
      .err_count(a_err), .sram_csb0(a_csb0), .sram_web0(a_web0), .sram_wmask0(a_wmask0),
      .sram_addr0(a_addr0), .sram_din0(a_din0), .sram_dout0(a_dout0), .sram_csb1(a_csb1),
      .sram_addr1(a_addr1), .sram_dout1(a_dout1));

   sram_march_bist #(.READ_PORT(0)) u_p0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .busy(b_busy), .done(b_done),
      .fail(b_fail), .fail_addr(b_faddr), .fail_elem(b_felem), .fail_data(b_fdata),
      .err_count(b_err), .sram_csb0(b_csb0), .sram_web0(b_web0), .sram_wmask0(b_wmask0),
      .sram_addr0(b_addr0), .sram_din0(b_din0), .sram_dout0(b_dout0), .sram_csb1(b_csb1),
      .sram_addr1(b_addr1), .sram_dout1(b_dout1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Stuck-at bit on the read path of one word
   function automatic logic [31:0] apply_fault(input logic [31:0] v, input int a);
      logic [31:0] m;
      m = 32'd1 << f_bit;
      if (f_en && (a == f_addr)) return f_val ? (v | m) : (v & ~m);
      return v;
   endfunction

   // Reference: walk March C- over an array, queue every command and the final result
   task automatic model_run();
      logic [31:0] store [DEPTH];
      res_t r;
      cmd_t c;
      logic [31:0] pat, got;
      int a, op;
      r = '0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < DEPTH; k++) begin
            a = (DOWN[e] != 0) ? (DEPTH - 1 - k) : k;
            for (int o = 0; o < NOPS[e]; o++) begin
               op = OPS[e][o];
               pat = ((op % 2) == 1) ? ~BG : BG;
               c.addr = a[AW-1:0];
               if (op >= 2) begin
                  c.wr = 1'b0;
                  c.data = '0;
                  got = apply_fault(store[a], a);
                  if (got != pat) begin
                     if (!r.fail) begin
                        r.fail = 1'b1;
                        r.addr = a[AW-1:0];
                        r.elem = e[2:0];
                        r.data = got ^ pat;
                     end
                     if (r.err != 16'hFFFF) r.err = r.err + 16'd1;
                  end
               end else begin
                  c.wr = 1'b1;
                  c.data = pat;
                  store[a] = pat;
               end
               q_cmd1.push_back(c);
               q_cmd0.push_back(c);
            end
         end
      end
      q_res1.push_back(r);
      q_res0.push_back(r);
   endtask

   // Macro models: capture at posedge, data valid after negedge, garbage after next posedge
   always @(posedge clk) begin
      if (!a_csb0 && !a_web0) mem1[a_addr0] <= a_din0;
      rp1 <= !a_csb1;
      ra1 <= a_addr1;
      if (!b_csb0 && !b_web0) mem0[b_addr0] <= b_din0;
      rp0 <= !b_csb0 && b_web0;
      ra0 <= b_addr0;
   end

   always begin
      @(negedge clk);
      if (rp1) a_dout1 = apply_fault(mem1[ra1], int'(ra1));
      if (rp0) b_dout0 = apply_fault(mem0[ra0], int'(ra0));
      @(posedge clk);
      #1;
      a_dout1 = $urandom();
      b_dout0 = $urandom();
      a_dout0 = $urandom();
      b_dout1 = $urandom();
   end

   // Monitor, read-on-port-1 instance: command stream and end-of-run result
   always @(negedge clk) begin : mon_p1
      logic [47:0] obs, expv;
      cmd_t c;
      res_t r;
      if (!rst && (!a_csb0 || !a_csb1)) begin
         cnt1++;
         obs = {a_csb0, a_csb1, (a_csb0 ? 1'b1 : a_web0),
                ((!a_csb0 && !a_web0) ? a_wmask0 : 4'h0),
                (!a_csb0 ? a_addr0 : a_addr1),
                ((!a_csb0 && !a_web0) ? a_din0 : 32'h0)};
         if (q_cmd1.size() > 0) begin
            c = q_cmd1.pop_front();
            expv = c.wr ? {1'b0, 1'b1, 1'b0, 4'hF, c.addr, c.data}
                        : {1'b1, 1'b0, 1'b1, 4'h0, c.addr, 32'h0};
         end else begin
            expv = '1;
         end
         check("p1_cmd", 64'(obs), 64'(expv));
      end
      if (a_done && !prev1) begin
         dn1++;
         r = (q_res1.size() > 0) ? q_res1.pop_front() : '1;
         check("p1_fail", 64'(a_fail), 64'(r.fail));
         check("p1_fail_addr", 64'(a_faddr), 64'(r.addr));
         check("p1_fail_elem", 64'(a_felem), 64'(r.elem));
         check("p1_fail_data", 64'(a_fdata), 64'(r.data));
         check("p1_err_count", 64'(a_err), 64'(r.err));
         check("p1_done_latency", 64'(cyc + 1 - t0), 64'd5122);
         check("p1_cmd_count", 64'(cnt1), 64'd5120);
      end
      prev1 = a_done;
   end

   // Monitor, read-on-port-0 instance: port 1 must stay deselected throughout
   always @(negedge clk) begin : mon_p0
      logic [47:0] obs, expv;
      cmd_t c;
      res_t r;
      if (!rst && (!b_csb0 || !b_csb1)) begin
         cnt0++;
         obs = {b_csb0, b_csb1, (b_csb0 ? 1'b1 : b_web0),
                ((!b_csb0 && !b_web0) ? b_wmask0 : 4'h0),
                (!b_csb0 ? b_addr0 : b_addr1),
                ((!b_csb0 && !b_web0) ? b_din0 : 32'h0)};
         if (q_cmd0.size() > 0) begin
            c = q_cmd0.pop_front();
            expv = c.wr ? {1'b0, 1'b1, 1'b0, 4'hF, c.addr, c.data}
                        : {1'b0, 1'b1, 1'b1, 4'h0, c.addr, 32'h0};
         end else begin
            expv = '1;
         end
         check("p0_cmd", 64'(obs), 64'(expv));
      end
      if (b_done && !prev0) begin
         dn0++;
         r = (q_res0.size() > 0) ? q_res0.pop_front() : '1;
         check("p0_fail", 64'(b_fail), 64'(r.fail));
         check("p0_fail_addr", 64'(b_faddr), 64'(r.addr));
         check("p0_fail_elem", 64'(b_felem), 64'(r.elem));
         check("p0_fail_data", 64'(b_fdata), 64'(r.data));
         check("p0_err_count", 64'(b_err), 64'(r.err));
         check("p0_done_latency", 64'(cyc + 1 - t0), 64'd5122);
         check("p0_cmd_count", 64'(cnt0), 64'd5120);
      end
      prev0 = b_done;
   end

   task automatic pulse_start();
      @(posedge clk);
      #2;
      start = 1'b1;
      t0 = cyc + 1;
      cnt1 = 0;
      cnt0 = 0;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; (i < 6000) && ((dn1 < exp_dn) || (dn0 < exp_dn)); i++) @(posedge clk);
      check("p1_run_complete", 64'(dn1), 64'(exp_dn));
      check("p0_run_complete", 64'(dn0), 64'(exp_dn));
      #2;
   endtask

   task automatic do_run(input bit en, input int fa, input int fb, input bit fv, input bit late);
      f_en = en;
      f_addr = fa;
      f_bit = fb;
      f_val = fv;
      model_run();
      exp_dn++;
      pulse_start();
      if (late) begin
         repeat (99) @(posedge clk);
         #2;
         start = 1'b1;
         @(posedge clk);
         #2;
         start = 1'b0;
      end
      wait_done();
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      a_dout0 = '0; a_dout1 = '0; b_dout0 = '0; b_dout1 = '0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy", 64'(a_busy), 64'd0);
      check("rst_done", 64'(a_done), 64'd0);
      check("rst_fail", 64'(a_fail), 64'd0);
      check("rst_err_count", 64'(a_err), 64'd0);
      check("rst_fail_addr", 64'(a_faddr), 64'd0);
      check("rst_csb", 64'({a_csb0, a_csb1, b_csb0, b_csb1}), 64'hF);
      check("rst_web0_wmask0", 64'({a_web0, a_wmask0}), 64'h10);
      rst = 1'b0;
      repeat (3) @(posedge clk);

      do_run(1'b0, 0, 0, 1'b0, 1'b0);             // clean
      do_run(1'b1, 37, 4, 1'b1, 1'b0);            // word 37 bit 4 stuck-1
      do_run(1'b0, 0, 0, 1'b0, 1'b1);             // clean, extra start while busy
      for (int i = 0; i < 3; i++) begin
         do_run(1'b1, int'($urandom_range(511, 0)), int'($urandom_range(31, 0)),
                1'b1 & $urandom_range(1, 0), 1'b0);
      end

      // Abort a failing run mid-way with reset (word 5 bit 0 stuck-0 misses in E1)
      f_en = 1'b1; f_addr = 5; f_bit = 0; f_val = 1'b0;
      model_run();
      pulse_start();
      repeat (1998) @(posedge clk);
      #2;
      check("pre_rst_busy", 64'(a_busy), 64'd1);
      check("pre_rst_fail", 64'(a_fail), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_csb", 64'({a_csb0, a_csb1, b_csb0, b_csb1}), 64'hF);
      check("abort_busy_done_fail", 64'({a_busy, a_done, a_fail, b_busy, b_done, b_fail}), 64'd0);
      q_cmd1.delete(); q_cmd0.delete(); q_res1.delete(); q_res0.delete();
      @(posedge clk);
      #2;
      rst = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("start_at_rst_release", 64'({a_busy, b_busy, a_csb0, a_csb1}), 64'h3);
      do_run(1'b0, 0, 0, 1'b0, 1'b0);             // fresh run after abort

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
